rca_pipe: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor: the successor to the fixed-width 32/64-bit ripple-carry adders. The operand width is split into SEG-bit segments, and one segment is resolved per pipeline stage, so clock frequency is independent of WIDTH. The block adds signed overflow, a subtract mode and a valid/ready handshake on both sides, and it sits between operand producers and result consumers in the datapath.

---
 rtl/rca_pkg.sv | 12 +
 rtl/rca_seg.sv | 25 ++
 rtl/rca_pipe.sv | 138 +++++++++++++
 tb/tb_rca_pipe.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
package rca_pkg;

  localparam int RCA_DEF_WIDTH = 64;
  localparam int RCA_DEF_SEG   = 16;

  // Number of pipeline stages: one SEG-bit segment resolved per stage.
  function automatic int rca_stages(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/rca_seg.sv
// Combinational SEG-bit ripple-carry adder built from a chain of full adders.
module rca_seg
  import rca_pkg::*;
#(
  parameter int SEG = RCA_DEF_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  logic [SEG:0] c;

  assign c[0] = ci;

  for (genvar j = 0; j < SEG; j++) begin : g_fa
    assign s[j]   = a[j] ^ b[j] ^ c[j];
    assign c[j+1] = (a[j] & b[j]) | (c[j] & (a[j] ^ b[j]));
  end

  assign co = c[SEG];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor. One SEG-bit segment is resolved per
// stage; unprocessed operand bits ride along with the beat and resolved sum
// bits accumulate, so each stage register shrinks/grows triangularly.
//
// Handshake: a beat moves on an edge where valid && ready. The pipeline stalls
// globally: advance = !out_valid || out_ready, and in_ready = advance, so a
// held result freezes every stage and blocks the input in the same cycle.
module rca_pipe
  import rca_pkg::*;
#(
  parameter int WIDTH = RCA_DEF_WIDTH,
  parameter int SEG   = RCA_DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = rca_stages(WIDTH, SEG);

  if ((SEG < 1) || (WIDTH % SEG != 0) || (STAGES < 1)) begin : g_bad_param
    $error("rca_pipe: WIDTH must be a non-zero multiple of SEG");
  end

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && in_ready;

  // Subtraction is a + ~b + 1; the caller's cin is ignored in that mode.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : cin;

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    localparam int LO = i * SEG;
    localparam int HI = (i + 1) * SEG;

    logic [WIDTH-LO-1:0] src_a;
    logic [WIDTH-LO-1:0] src_b;
    logic                src_c;
    logic                src_v;
    logic [HI-1:0]       sum_d;
    logic [SEG-1:0]      seg_s;
    logic                seg_co;

    logic                v_q;
    logic                c_q;
    logic [HI-1:0]       sum_q;

    if (i == 0) begin : g_src
      assign src_a = a;
      assign src_b = b_eff;
      assign src_c = c_eff;
      assign src_v = accept;
      assign sum_d = seg_s;
    end else begin : g_src
      assign src_a = g_stage[i-1].g_rem.rem_a_q;
      assign src_b = g_stage[i-1].g_rem.rem_b_q;
      assign src_c = g_stage[i-1].c_q;
      assign src_v = g_stage[i-1].v_q;
      assign sum_d = {seg_s, g_stage[i-1].sum_q};
    end

    rca_seg #(.SEG(SEG)) u_seg (
      .a  (src_a[SEG-1:0]),
      .b  (src_b[SEG-1:0]),
      .ci (src_c),
      .s  (seg_s),
      .co (seg_co)
    );

    // Valid shifts on every advance; data only loads when a real beat arrives.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        v_q <= src_v;
        if (src_v) begin
          c_q   <= seg_co;
          sum_q <= sum_d;
        end
      end
    end

    if (i < STAGES - 1) begin : g_rem
      logic [WIDTH-HI-1:0] rem_a_q;
      logic [WIDTH-HI-1:0] rem_b_q;

      // Carry the not-yet-added operand segments forward with the beat.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rem_a_q <= '0;
          rem_b_q <= '0;
        end else if (advance && src_v) begin
          rem_a_q <= src_a[WIDTH-LO-1:SEG];
          rem_b_q <= src_b[WIDTH-LO-1:SEG];
        end
      end
    end else begin : g_last
      logic a_msb_q;
      logic b_msb_q;

      // Keep the operand sign bits for the signed-overflow decision.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_msb_q <= 1'b0;
          b_msb_q <= 1'b0;
        end else if (advance && src_v) begin
          a_msb_q <= src_a[SEG-1];
          b_msb_q <= src_b[SEG-1];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign s         = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = (g_stage[STAGES-1].g_last.a_msb_q == g_stage[STAGES-1].g_last.b_msb_q)
                  && (s[WIDTH-1] != g_stage[STAGES-1].g_last.a_msb_q);

endmodule

// File: tb/tb_rca_pipe.sv
// Bench for rca_pipe: 64/16 instance with random streams and a reference
// model, plus an 8/8 single-stage instance.
module tb_rca_pipe;

  localparam int W  = 64;
  localparam int SG = 16;
  localparam int ST = W / SG;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid  = 1'b0;
  logic         in_ready;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;
  logic         cin       = 1'b0;
  logic         sub       = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

  logic         in_valid8  = 1'b0;
  logic         in_ready8;
  logic [7:0]   a8         = '0;
  logic [7:0]   b8         = '0;
  logic         cin8       = 1'b0;
  logic         sub8       = 1'b0;
  logic         out_valid8;
  logic         out_ready8 = 1'b1;
  logic [7:0]   s8;
  logic         cout8;
  logic         ovf8;

  rca_pipe #(.WIDTH(W), .SEG(SG)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
  );

  rca_pipe #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8),
    .out_ready(out_ready8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [W+1:0] exp_q[$];

  task automatic check(input string nm, input logic [W+1:0] act, input logic [W+1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic. Result packed as {ovf, cout, s}.
  // Overflow = the exact signed result differs from the wrapped result read as signed.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sb);
    logic [W:0]   us;
    logic [W+1:0] exact;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    if (sb) begin
      r     = x - y;
      co    = (x >= y);
      exact = {{2{x[W-1]}}, x} - {{2{y[W-1]}}, y};
    end else begin
      us    = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      r     = us[W-1:0];
      co    = us[W];
      exact = {{2{x[W-1]}}, x} + {{2{y[W-1]}}, y} + {{(W+1){1'b0}}, ci};
    end
    ov = (exact != {{2{r[W-1]}}, r});
    return {ov, co, r};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic         stall_prev = 1'b0;
  logic [W+1:0] held       = '0;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (stall_prev)
        check("held_output", {out_valid, ovf, cout, s}, {1'b1, held});
      if (in_valid && in_ready)
        exp_q.push_back(model(a, b, cin, sub));
      if (out_valid && out_ready) begin
        n_out++;
        check("out_has_beat", exp_q.size() > 0, 1);
        if (exp_q.size() > 0)
          check("result", {ovf, cout, s}, exp_q.pop_front());
      end
      stall_prev = out_valid && !out_ready;
      held       = {ovf, cout, s};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic sb, input logic [W-1:0] es,
                          input logic ec, input logic eo);
    int lat;
    check({nm, "_model"}, model(x, y, ci, sb), {eo, ec, es});
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    @(negedge clk);
    check({nm, "_accept"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom};
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check({nm, "_latency"}, lat, ST);
    check({nm, "_value"}, {ovf, cout, s}, {eo, ec, es});
    tick();
  endtask

  task automatic run_stream(input int n, input bit stall_window);
    int  sent = 0;
    int  c    = 0;
    int  base = n_out;
    bit  have = 0;
    while (sent < n && c < 400) begin
      out_ready = stall_window ? !(c >= 3 && c <= 5) : ($urandom_range(0, 3) != 0);
      if (!have) begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom};
        cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
        have = 1;
      end
      in_valid = stall_window ? 1'b1 : ($urandom_range(0, 4) != 0);
      @(negedge clk);
      if (stall_window && (c == 4 || c == 5)) begin
        check("stall_out_valid", out_valid, 1);
        check("stall_in_ready", in_ready, 0);
      end
      if (in_valid && in_ready) begin
        sent++;
        have = 0;
      end
      tick();
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      tick();
      c++;
    end
    tick();
    check("drain_empty", exp_q.size(), 0);
    check("beat_count", n_out - base, n);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_s", {ovf, cout, s}, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst8_state", {out_valid8, ovf8, cout8, s8}, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    directed("wrap_add", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0);
    directed("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    directed("ovf_add", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
             64'h8000_0000_0000_0000, 1'b0, 1'b1);
    directed("ovf_sub", 64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
             64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    directed("sub_cin_ignored", 64'd10, 64'd3, 1'b1, 1'b1, 64'd7, 1'b1, 1'b0);
    directed("add_cin", 64'h0000_0000_0000_FFFF, 64'd0, 1'b1, 1'b0,
             64'h0000_0000_0001_0000, 1'b0, 1'b0);

    run_stream(8, 1'b1);
    run_stream(60, 1'b0);

    // Reset with three beats in flight.
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'b0; cin = 1'b1;
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_s", {ovf, cout, s}, 0);
    check("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("post_rst_idle", out_valid, 0);
      tick();
    end

    // Single-stage instance: registered adder, one-cycle latency.
    a8 = 8'h7F; b8 = 8'h00; cin8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1;
    @(negedge clk);
    check("w8_accept", in_ready8, 1);
    check("w8_not_yet", out_valid8, 0);
    tick();
    in_valid8 = 1'b0;
    a8 = 8'h55;
    @(negedge clk);
    check("w8_value", {out_valid8, ovf8, cout8, s8}, {1'b1, 1'b1, 1'b0, 8'h80});
    tick();
    a8 = 8'h80; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b1; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    @(negedge clk);
    check("w8_sub_ovf", {out_valid8, ovf8, cout8, s8}, {1'b1, 1'b1, 1'b1, 8'h7F});
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
